// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port between the ALU result path and
// the LSU load-return path. Loads win by default; a starvation counter forces
// the ALU through after MAX_WAIT consecutive denied cycles. The write port is
// registered: a request accepted in cycle N is written in cycle N+1.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous flush, cancels this cycle's grants
//   alu_valid/rd/data       ALU writeback request
//   alu_ready               ALU request accepted this cycle (combinational)
//   lsu_valid/rd/data       load writeback request
//   lsu_ready               load request accepted this cycle (combinational)
//   rf_wr_en/addr/data      registered register-file write port
//   grant_src               source of last accepted request (0 ALU, 1 LSU)
//   alu_starve              current count of consecutive denied ALU cycles
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4,
  localparam int SW      = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              grant_src,
  output logic [SW-1:0]     alu_starve
);

  localparam logic [SW-1:0] MAX_CNT = SW'(MAX_WAIT);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  logic              alu_acc;
  logic              lsu_acc;
  logic              accept;
  logic              alu_forced;
  src_e              win_src;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // Ready is a function of valids, flush and the starvation count only, so a
  // requester may wait on ready without forming a combinational loop. rst_n
  // gates both readies so nothing is accepted while reset is held.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    alu_ready  = 1'b0;
    lsu_ready  = 1'b0;
    alu_forced = (alu_starve >= MAX_CNT);
    if (rst_n && !flush) begin
      if (alu_valid && (!lsu_valid || alu_forced)) begin
        alu_ready = 1'b1;
      end else if (lsu_valid) begin
        lsu_ready = 1'b1;
      end
    end
  end

  assign alu_acc  = alu_valid && alu_ready;
  assign lsu_acc  = lsu_valid && lsu_ready;
  assign accept   = alu_acc || lsu_acc;
  assign win_src  = lsu_acc ? SRC_LSU : SRC_ALU;
  assign win_rd   = lsu_acc ? lsu_rd   : alu_rd;
  assign win_data = lsu_acc ? lsu_data : alu_data;

  // Starvation counter: clears whenever the ALU is not actually waiting.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_starve <= '0;
    end else if (flush || !alu_valid || alu_acc) begin
      alu_starve <= '0;
    end else if (alu_starve < MAX_CNT) begin
      alu_starve <= alu_starve + 1'b1;
    end
  end

  // Output stage. A write to x0 is consumed but never reaches the register
  // file; address, data and source still load so they reflect the last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      grant_src  <= 1'b0;
    end else begin
      rf_wr_en <= accept && (win_rd != '0);
      if (accept) begin
        rf_wr_addr <= win_rd;
        rf_wr_data <= win_data;
        grant_src  <= win_src;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed vectors with hand-computed expectations. The stimulus process drives
// one vector per cycle and pushes the expected handshake and, for accepted
// requests, the expected register-file write into queues. A monitor samples
// the DUT on the falling edge and pops/compares.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 4;
  localparam int SW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          grant_src;
  logic [SW-1:0] alu_starve;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .grant_src  (grant_src),
    .alu_starve (alu_starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ar;
    logic          lr;
    logic [SW-1:0] starve;
  } hs_t;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          src;
  } wr_t;

  hs_t hs_q[$];
  wr_t wr_q[$];

  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, push expectations.
  task automatic apply(input logic fl,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                       input logic exp_ar, input logic exp_lr, input int exp_st);
    hs_t h;
    wr_t w;
    @(posedge clk);
    #1;
    flush = fl;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    h.ar = exp_ar; h.lr = exp_lr; h.starve = SW'(exp_st);
    hs_q.push_back(h);
    if (exp_ar) begin
      w.en = (ard != 0); w.addr = ard; w.data = adat; w.src = 1'b0;
      wr_q.push_back(w);
    end
    if (exp_lr) begin
      w.en = (lrd != 0); w.addr = lrd; w.data = ldat; w.src = 1'b1;
      wr_q.push_back(w);
    end
  endtask

  task automatic idle(input int exp_st);
    apply(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, exp_st);
  endtask

  // Monitor: on each falling edge, first check the write produced by the
  // previous cycle's accept (or that the port stayed quiet), then check the
  // current cycle's handshake and remember whether a transfer is happening.
  initial begin : monitor
    bit  prev_acc = 1'b0;
    hs_t h;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_acc = 1'b0;
      end else begin
        if (prev_acc) begin
          if (wr_q.size() == 0) begin
            check("wr_unexpected_accept", 64'd1, 64'd0);
          end else begin
            w = wr_q.pop_front();
            check("rf_wr_en",   64'(rf_wr_en),   64'(w.en));
            check("rf_wr_addr", 64'(rf_wr_addr), 64'(w.addr));
            check("rf_wr_data", 64'(rf_wr_data), 64'(w.data));
            check("grant_src",  64'(grant_src),  64'(w.src));
          end
        end else begin
          check("rf_wr_en_idle", 64'(rf_wr_en), 64'd0);
        end
        if (hs_q.size() != 0) begin
          h = hs_q.pop_front();
          check("alu_ready",  64'(alu_ready),  64'(h.ar));
          check("lsu_ready",  64'(lsu_ready),  64'(h.lr));
          check("alu_starve", 64'(alu_starve), 64'(h.starve));
        end
        prev_acc = (alu_valid && alu_ready) || (lsu_valid && lsu_ready);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    #12;
    check("reset_rf_wr_en",   64'(rf_wr_en),   64'd0);
    check("reset_rf_wr_addr", 64'(rf_wr_addr), 64'd0);
    check("reset_rf_wr_data", 64'(rf_wr_data), 64'd0);
    check("reset_grant_src",  64'(grant_src),  64'd0);
    check("reset_alu_starve", 64'(alu_starve), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // ALU-only transfer.
    apply(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0);
    // Load to x0: consumed, no write issued.
    apply(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0, 1, 0);
    idle(0);

    // Starvation: both valid continuously; ALU holds rd 7 until forced through.
    for (int i = 0; i < 4; i++)
      apply(0, 1, 5'd7, 32'hA1A1A1A1, 1, AW'(10 + i), 32'h5000 + i, 0, 1, i);
    apply(0, 1, 5'd7, 32'hA1A1A1A1, 1, 5'd14, 32'h5004, 1, 0, 4);
    // Counter cleared; loads win again while the next ALU result waits.
    apply(0, 1, 5'd8, 32'hB2B2B2B2, 1, 5'd14, 32'h5004, 0, 1, 0);
    apply(0, 1, 5'd8, 32'hB2B2B2B2, 1, 5'd15, 32'h5005, 0, 1, 1);
    apply(0, 1, 5'd8, 32'hB2B2B2B2, 1, 5'd16, 32'h5006, 0, 1, 2);
    // Flush with alu_starve=3: nothing granted, counter clears.
    apply(1, 1, 5'd8, 32'hB2B2B2B2, 1, 5'd17, 32'h5007, 0, 0, 3);
    idle(0);

    // Back-to-back ALU stream, rd 1..8.
    for (int i = 1; i <= 8; i++)
      apply(0, 1, AW'(i), 32'h100 + i, 0, 0, 0, 1, 0, 0);
    // LSU-only, top register and all-ones data.
    apply(0, 0, 0, 0, 1, 5'd31, 32'hFFFFFFFF, 0, 1, 0);
    idle(0);
    idle(0);

    @(negedge clk);
    mon_en = 1'b0;
    check("hs_queue_drained", 64'(hs_q.size()), 64'd0);
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);

    // Async reset while a write is being presented and the ALU is starved.
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h55;
    @(posedge clk); #1;
    lsu_rd = 5'd4; lsu_data = 32'h66;
    check("pre_reset_rf_wr_en",   64'(rf_wr_en),   64'd1);
    check("pre_reset_alu_starve", 64'(alu_starve), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rf_wr_en",   64'(rf_wr_en),   64'd0);
    check("async_rf_wr_addr", 64'(rf_wr_addr), 64'd0);
    check("async_rf_wr_data", 64'(rf_wr_data), 64'd0);
    check("async_alu_starve", 64'(alu_starve), 64'd0);
    check("async_alu_ready",  64'(alu_ready),  64'd0);
    check("async_lsu_ready",  64'(lsu_ready),  64'd0);
    @(posedge clk); #1;
    check("held_rst_rf_wr_en", 64'(rf_wr_en),  64'd0);
    check("held_rst_lsu_ready", 64'(lsu_ready), 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h77;
    #1;
    check("post_reset_alu_ready", 64'(alu_ready), 64'd1);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    check("post_reset_rf_wr_en",   64'(rf_wr_en),   64'd1);
    check("post_reset_rf_wr_addr", 64'(rf_wr_addr), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU/EX result path and the LSU load-return path.
- Sits between the execute/memory stages and the register file write port (wr_en/wr_addr/wr_data).
- Load returns win by default. An anti-starvation counter guarantees ALU progress.
- Output is registered: one write per cycle, one cycle after acceptance.

Parameters:
- DATA_W, 32, width of writeback data.
- ADDR_W, 5, register index width.
- MAX_WAIT, 4, number of consecutive denied ALU cycles before the ALU is forced to win (must be >= 1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; cancels this cycle's grants.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- lsu_valid  in  1  load writeback request.
- lsu_rd  in  ADDR_W  load destination register.
- lsu_data  in  DATA_W  load data.
- lsu_ready  out  1  load request accepted this cycle (combinational).
- rf_wr_en  out  1  registered write enable to the register file.
- rf_wr_addr  out  ADDR_W  registered write address.
- rf_wr_data  out  DATA_W  registered write data.
- grant_src  out  1  source of the last accepted request (0 = ALU, 1 = LSU), registered.
- alu_starve  out  clog2(MAX_WAIT+1)  current starvation count.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, grant_src=0, alu_starve=0.
  - While rst_n is low, alu_ready=0 and lsu_ready=0.
  - Reset mid-transfer discards the pending write; rf_wr_en drops immediately and asynchronously.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester holds valid, rd and data stable until accepted.
  - ready depends on the valid inputs, flush and alu_starve only; it never depends on itself.
- Arbitration, evaluated combinationally each cycle; at most one ready is high per cycle:
  - flush=1: both ready=0.
  - Only one valid: that requester gets ready=1.
  - Both valid and alu_starve >= MAX_WAIT: ALU wins.
  - Both valid otherwise: LSU wins.
- Starvation counter, per clock edge:
  - flush=1 or alu_valid=0, or ALU accepted: clear to 0.
  - alu_valid && !alu_ready: increment, saturating at MAX_WAIT.
- Output stage, per clock edge:
  - On any accept, rf_wr_addr and rf_wr_data load the winner's rd and data, and grant_src loads the winner ID.
  - rf_wr_en <= accept && (winner rd != 0). A request to x0 is accepted and consumed, but no write is issued.
  - No accept (idle or flush): rf_wr_en <= 0; addr, data and grant_src hold their previous values.
- Latency and throughput:
  - Accept at cycle N gives rf_wr_en at cycle N+1.
  - Throughput is one write per cycle, with no bubbles under continuous load.
  - The register file's same-cycle write-to-read forwarding covers the read-after-write in cycle N+1.
- Ordering: no reordering within a single requester. Between requesters, order follows the grant sequence. Same-rd ordering across requesters is the issue logic's responsibility.

Test Plan:
- ALU-only transfer: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, lsu_valid=0 -> alu_ready=1 same cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, grant_src=0.
- Starvation limit: both valid continuously from cycle 0, MAX_WAIT=4 -> lsu_ready high in cycles 0-3, alu_starve counts 0,1,2,3,4; cycle 4 alu_ready=1; cycle 5 alu_starve=0 and the LSU wins again.
- Write to x0: lsu_valid=1, lsu_rd=0, lsu_data=0x1234 -> lsu_ready=1; next cycle rf_wr_en=0, rf_wr_addr=0, grant_src=1.
- Flush: both valid with alu_starve=3, flush=1 for one cycle -> both ready=0; next cycle rf_wr_en=0, alu_starve=0.
- Back-to-back throughput: alu_valid held high for 8 cycles with rd 1..8 -> rf_wr_en high for 8 consecutive cycles, addresses 1..8 in order.
- Async reset: rst_n asserted low mid-cycle while rf_wr_en=1 -> rf_wr_en, rf_wr_addr, rf_wr_data and alu_starve go to 0 without a clock edge; both ready=0 until release.
